// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU constants, DMA state enum and address helpers
//
// Contents:
//   dma_state_t   OAM DMA controller states (IDLE, START, XFER)
//   FF46_ADDR     DMA source page register address
//   OAM_BASE      CPU-visible base address of OAM
//   HRAM_LO/HI    HRAM window; CPU accesses here are never stalled by DMA
//   dma_src_hi    source page after the echo-RAM fold (E0..FF -> C0..DF)
//   oam_bus_addr  CPU-visible OAM address of a byte index
package ppu_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_START = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [15:0] FF46_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;

  // Pages above DF sit in echo RAM, which mirrors work RAM 0x2000 lower.
  function automatic logic [7:0] dma_src_hi(input logic [7:0] page);
    return (page <= 8'hDF) ? page : page - 8'h20;
  endfunction

  function automatic logic [15:0] oam_bus_addr(input logic [7:0] idx);
    return OAM_BASE + {8'h00, idx};
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU register port, source read port and OAM write port of the DMA block
//
// CPU side:    ADDR, WR, RD, MMIO_DATA_out (write data), MMIO_DATA_in (readback), CPU_STALL
// Source side: DMA_RD, DMA_SRC_ADDR, DMA_DATA_in (valid one clock after DMA_RD)
// OAM side:    OAM_WR, OAM_ADDR, OAM_DATA
// Status:      DMA_ACTIVE
// slave = the DMA controller, master = the system driving it.
interface oam_dma_ctrl_if;
  logic [15:0] ADDR;
  logic        WR;
  logic        RD;
  logic [7:0]  MMIO_DATA_out;
  logic [7:0]  MMIO_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_SRC_ADDR;
  logic [7:0]  DMA_DATA_in;
  logic        OAM_WR;
  logic [7:0]  OAM_ADDR;
  logic [7:0]  OAM_DATA;
  logic        DMA_ACTIVE;
  logic        CPU_STALL;

  modport slave (
    input  ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
    output MMIO_DATA_in, DMA_RD, DMA_SRC_ADDR, OAM_WR, OAM_ADDR, OAM_DATA,
           DMA_ACTIVE, CPU_STALL
  );

  modport master (
    output ADDR, WR, RD, MMIO_DATA_out, DMA_DATA_in,
    input  MMIO_DATA_in, DMA_RD, DMA_SRC_ADDR, OAM_WR, OAM_ADDR, OAM_DATA,
           DMA_ACTIVE, CPU_STALL
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA controller: FF46 write copies XFER_LEN bytes from page FF46 into OAM
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  oam_dma_ctrl_if.slave (CPU register port, source read port, OAM write port)
// Each byte slot lasts CYCLES_PER_BYTE clocks: phase 0 reads the source,
// phase 1 writes the returned byte to OAM, remaining phases are idle.
module oam_dma_ctrl
  import ppu_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int XFER_LEN        = 160
) (
  input  logic            clk,
  input  logic            rst,
  oam_dma_ctrl_if.slave   bus
);

  localparam int IDX_W = (XFER_LEN > 1) ? $clog2(XFER_LEN) : 1;
  localparam int PH_W  = $clog2(CYCLES_PER_BYTE);
  localparam int DL_W  = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  dma_state_t       state, state_nxt;
  logic [7:0]       ff46;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;
  logic [DL_W-1:0]  delay, delay_nxt;

  logic ff46_wr;
  logic in_hram;

  assign ff46_wr = bus.WR && (bus.ADDR == FF46_ADDR);
  assign in_hram = (bus.ADDR >= HRAM_LO) && (bus.ADDR <= HRAM_HI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DMA_IDLE;
      ff46  <= '0;
      idx   <= '0;
      phase <= '0;
      delay <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      phase <= phase_nxt;
      delay <= delay_nxt;
      if (ff46_wr) begin
        ff46 <= bus.MMIO_DATA_out;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    phase_nxt = phase;
    delay_nxt = delay;
    case (state)
      DMA_IDLE: begin
      end
      DMA_START: begin
        if (delay == DL_W'(START_DELAY - 1)) begin
          state_nxt = DMA_XFER;
          delay_nxt = '0;
        end else begin
          delay_nxt = delay + 1'b1;
        end
      end
      DMA_XFER: begin
        if (phase == PH_W'(CYCLES_PER_BYTE - 1)) begin
          phase_nxt = '0;
          // The last byte returns to IDLE instead of incrementing, so the
          // index never wraps even when XFER_LEN fills its width.
          if (idx == IDX_W'(XFER_LEN - 1)) begin
            state_nxt = DMA_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = DMA_IDLE;
    endcase
    // A new FF46 write overrides everything and restarts the copy.
    if (ff46_wr) begin
      state_nxt = DMA_START;
      idx_nxt   = '0;
      phase_nxt = '0;
      delay_nxt = '0;
    end
  end

  always_comb begin
    bus.DMA_RD       = 1'b0;
    bus.DMA_SRC_ADDR = 16'h0000;
    bus.OAM_WR       = 1'b0;
    bus.OAM_ADDR     = 8'h00;
    bus.OAM_DATA     = 8'h00;
    if (state == DMA_XFER) begin
      if (phase == '0) begin
        bus.DMA_RD       = 1'b1;
        bus.DMA_SRC_ADDR = {dma_src_hi(ff46), 8'(idx)};
      end else if (phase == PH_W'(1) && !ff46_wr) begin
        // Suppressed when a restart write lands on the write phase so the
        // aborted slot never reaches OAM.
        bus.OAM_WR   = 1'b1;
        bus.OAM_ADDR = 8'(idx);
        bus.OAM_DATA = bus.DMA_DATA_in;
      end
    end
  end

  assign bus.DMA_ACTIVE   = (state == DMA_XFER);
  assign bus.CPU_STALL    = bus.DMA_ACTIVE && (bus.RD || bus.WR) && !in_hram && !ff46_wr;
  assign bus.MMIO_DATA_in = (bus.ADDR == FF46_ADDR) ? ff46 : 8'hFF;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - self-checking bench for oam_dma_ctrl (default and fast parameter sets)
module tb_oam_dma_ctrl;
  import ppu_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } oam_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  oam_dma_ctrl_if bus ();
  oam_dma_ctrl_if bus2 ();

  oam_dma_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  oam_dma_ctrl #(.CYCLES_PER_BYTE(2), .START_DELAY(1), .XFER_LEN(160))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic [7:0]  src_mem [0:65535];
  logic [7:0]  oam_mem [0:255];
  oam_t        sb1[$];
  oam_t        sb2[$];
  oam_t        exp1, exp2;
  int          n2_wr = 0;
  logic [15:0] rdq[$];

  // Source memory: registered read, data valid the clock after DMA_RD.
  always @(posedge clk) begin
    if (bus.DMA_RD === 1'b1) bus.DMA_DATA_in <= src_mem[bus.DMA_SRC_ADDR];
    if (bus2.DMA_RD === 1'b1) bus2.DMA_DATA_in <= src_mem[bus2.DMA_SRC_ADDR];
  end

  always @(negedge clk) begin
    if (bus.OAM_WR === 1'b1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL oam_wr_unexpected: got addr=%02h data=%02h, required no write", bus.OAM_ADDR, bus.OAM_DATA);
      end else begin
        exp1 = sb1.pop_front();
        if (bus.OAM_ADDR !== exp1.a || bus.OAM_DATA !== exp1.d) begin
          errors++;
          $display("FAIL oam_wr_data: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   bus.OAM_ADDR, bus.OAM_DATA, exp1.a, exp1.d);
        end
      end
      oam_mem[bus.OAM_ADDR] = bus.OAM_DATA;
    end
  end

  always @(negedge clk) begin
    if (bus2.OAM_WR === 1'b1) begin
      checks++;
      n2_wr++;
      if (sb2.size() == 0) begin
        errors++;
        $display("FAIL oam2_wr_unexpected: got addr=%02h data=%02h, required no write", bus2.OAM_ADDR, bus2.OAM_DATA);
      end else begin
        exp2 = sb2.pop_front();
        if (bus2.OAM_ADDR !== exp2.a || bus2.OAM_DATA !== exp2.d) begin
          errors++;
          $display("FAIL oam2_wr_data: got addr=%02h data=%02h, required addr=%02h data=%02h",
                   bus2.OAM_ADDR, bus2.OAM_DATA, exp2.a, exp2.d);
        end
      end
    end
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bus.ADDR = a; bus.MMIO_DATA_out = d; bus.WR = 1'b1; bus.RD = 1'b0;
    @(posedge clk); #1;
    bus.WR = 1'b0; bus.ADDR = 16'h0000;
  endtask

  // Counts inactive clocks before DMA_ACTIVE, then active clocks; records source reads and OAM_WR spacing.
  task automatic measure(input int gap, output int pre, output int act, output int n_wr, output int bad_gap);
    int last;
    pre = 0; act = 0; n_wr = 0; bad_gap = 0; last = 0;
    rdq.delete();
    @(negedge clk);
    while (bus.DMA_ACTIVE !== 1'b1 && pre < 2000) begin pre++; @(negedge clk); end
    while (bus.DMA_ACTIVE === 1'b1 && act < 2000) begin
      if (bus.DMA_RD === 1'b1) rdq.push_back(bus.DMA_SRC_ADDR);
      if (bus.OAM_WR === 1'b1) begin
        if (n_wr > 0 && (act - last) != gap) bad_gap++;
        last = act;
        n_wr++;
      end
      act++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int seen;
    bus.ADDR = FF46_ADDR; bus.WR = 1'b0; bus.RD = 1'b1; bus.MMIO_DATA_out = 8'h00;
    bus2.ADDR = 16'h0000; bus2.WR = 1'b0; bus2.RD = 1'b0; bus2.MMIO_DATA_out = 8'h00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.MMIO_DATA_in !== 8'h00) begin errors++; $display("FAIL reset_ff46: got %02h, required 00", bus.MMIO_DATA_in); end
    bus.ADDR = 16'hC000; #1;
    checks++;
    if ({bus.DMA_RD, bus.OAM_WR, bus.DMA_ACTIVE, bus.CPU_STALL} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b, required 0000", {bus.DMA_RD, bus.OAM_WR, bus.DMA_ACTIVE, bus.CPU_STALL});
    end
    checks++;
    if (bus.MMIO_DATA_in !== 8'hFF) begin errors++; $display("FAIL readback_other: got %02h, required ff", bus.MMIO_DATA_in); end
    @(posedge clk); #1;
    rst = 1'b1; bus.RD = 1'b0;
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.DMA_ACTIVE !== 1'b0 || bus.DMA_RD !== 1'b0) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL idle_after_reset: got %0d busy clocks, required 0", seen); end
  endtask

  task automatic test_basic_copy();
    int pre, act, nw, bg;
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
      sb1.push_back({8'(i), 8'(i) ^ 8'h5A});
    end
    cpu_write(FF46_ADDR, 8'hC1);
    measure(4, pre, act, nw, bg);
    checks++; if (pre != 4) begin errors++; $display("FAIL basic_start_delay: got %0d, required 4", pre); end
    checks++; if (act != 640) begin errors++; $display("FAIL basic_active_len: got %0d, required 640", act); end
    checks++; if (nw != 160) begin errors++; $display("FAIL basic_wr_count: got %0d, required 160", nw); end
    checks++; if (bg != 0) begin errors++; $display("FAIL basic_wr_spacing: got %0d bad gaps, required 0", bg); end
    checks++; if (rdq.size() != 160 || rdq[0] !== 16'hC100) begin errors++; $display("FAIL basic_first_rd: got %0d reads, required 160 starting at c100", rdq.size()); end
    checks++; if (oam_mem[159] !== (8'd159 ^ 8'h5A)) begin errors++; $display("FAIL basic_oam_last: got %02h, required %02h", oam_mem[159], 8'd159 ^ 8'h5A); end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL basic_missing_wr: got %0d left, required 0", sb1.size()); end
  endtask

  task automatic test_echo_mirror();
    int pre, act, nw, bg, bad;
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC300 + i] = 8'(i * 3);
      sb1.push_back({8'(i), 8'(i * 3)});
    end
    cpu_write(FF46_ADDR, 8'hE3);
    measure(4, pre, act, nw, bg);
    bad = 0;
    for (int i = 0; i < rdq.size(); i++) if (rdq[i] !== 16'(16'hC300 + i)) bad++;
    checks++; if (rdq.size() != 160 || bad != 0) begin errors++; $display("FAIL echo_src_addr: got %0d reads %0d wrong, required 160 reads c300..c39f", rdq.size(), bad); end
    bus.ADDR = FF46_ADDR; #1;
    checks++; if (bus.MMIO_DATA_in !== 8'hE3) begin errors++; $display("FAIL echo_readback: got %02h, required e3", bus.MMIO_DATA_in); end
    bus.ADDR = 16'h0000;
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL echo_missing_wr: got %0d left, required 0", sb1.size()); end
  endtask

  task automatic test_restart();
    int pre, act, nw, bg;
    bit found;
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC000 + i] = 8'(i + 1);
      src_mem[16'hD000 + i] = ~8'(i);
    end
    for (int i = 0; i < 50; i++) sb1.push_back({8'(i), 8'(i + 1)});
    for (int i = 0; i < 160; i++) sb1.push_back({8'(i), ~8'(i)});
    cpu_write(FF46_ADDR, 8'hC0);
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (bus.DMA_RD === 1'b1 && bus.DMA_SRC_ADDR === 16'hC032) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL restart_reach_byte50: got timeout, required read of c032"); end
    bus.ADDR = FF46_ADDR; bus.MMIO_DATA_out = 8'hD0; bus.WR = 1'b1; #1;
    checks++; if (bus.CPU_STALL !== 1'b0) begin errors++; $display("FAIL ff46_write_stall: got %b, required 0", bus.CPU_STALL); end
    @(posedge clk); #1;
    bus.WR = 1'b0; bus.ADDR = 16'h0000;
    measure(4, pre, act, nw, bg);
    checks++; if (pre != 4 || act != 640) begin errors++; $display("FAIL restart_timing: got start %0d active %0d, required 4 and 640", pre, act); end
    checks++; if (oam_mem[50] !== ~8'd50 || oam_mem[0] !== 8'hFF) begin errors++; $display("FAIL restart_oam: got %02h %02h, required %02h ff", oam_mem[50], oam_mem[0], ~8'd50); end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL restart_missing_wr: got %0d left, required 0", sb1.size()); end
  endtask

  task automatic test_stall_and_reset();
    bit found;
    int seen;
    for (int i = 0; i < 160; i++) src_mem[16'hC200 + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 80; i++) sb1.push_back({8'(i), 8'(i) ^ 8'hA5});
    cpu_write(FF46_ADDR, 8'hC2);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin @(negedge clk); if (bus.DMA_ACTIVE === 1'b1) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach_xfer: got timeout, required DMA_ACTIVE"); end
    bus.RD = 1'b1; bus.ADDR = 16'hC000; #1;
    checks++; if (bus.CPU_STALL !== 1'b1) begin errors++; $display("FAIL stall_c000: got %b, required 1", bus.CPU_STALL); end
    bus.ADDR = 16'hFF90; #1;
    checks++; if (bus.CPU_STALL !== 1'b0) begin errors++; $display("FAIL stall_ff90: got %b, required 0", bus.CPU_STALL); end
    bus.ADDR = 16'hFFFF; #1;
    checks++; if (bus.CPU_STALL !== 1'b1) begin errors++; $display("FAIL stall_ffff: got %b, required 1", bus.CPU_STALL); end
    bus.ADDR = FF46_ADDR; #0.5;
    checks++; if (bus.MMIO_DATA_in !== 8'hC2) begin errors++; $display("FAIL xfer_readback: got %02h, required c2", bus.MMIO_DATA_in); end
    bus.RD = 1'b0; bus.ADDR = 16'h0000;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (bus.DMA_RD === 1'b1 && bus.DMA_SRC_ADDR === 16'hC250) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_reach_byte80: got timeout, required read of c250"); end
    rst = 1'b0; bus.RD = 1'b1; bus.ADDR = 16'hC000; #1;
    checks++;
    if ({bus.DMA_RD, bus.OAM_WR, bus.DMA_ACTIVE, bus.CPU_STALL} !== 4'b0000) begin
      errors++; $display("FAIL midreset_outputs: got %b, required 0000", {bus.DMA_RD, bus.OAM_WR, bus.DMA_ACTIVE, bus.CPU_STALL});
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; bus.RD = 1'b0; bus.ADDR = FF46_ADDR; #1;
    checks++; if (bus.MMIO_DATA_in !== 8'h00) begin errors++; $display("FAIL midreset_ff46: got %02h, required 00", bus.MMIO_DATA_in); end
    seen = 0;
    repeat (30) begin @(negedge clk); if (bus.DMA_ACTIVE !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_idle: got %0d active clocks, required 0", seen); end
    checks++; if (sb1.size() != 0) begin errors++; $display("FAIL midreset_missing_wr: got %0d left, required 0", sb1.size()); end
    bus.ADDR = 16'h0000;
  endtask

  task automatic test_params();
    int pre, act, bad;
    pre = 0; act = 0; bad = 0; n2_wr = 0;
    for (int i = 0; i < 160; i++) begin
      src_mem[16'hC400 + i] = 8'(i) + 8'h33;
      sb2.push_back({8'(i), 8'(i) + 8'h33});
    end
    bus2.ADDR = FF46_ADDR; bus2.MMIO_DATA_out = 8'hC4; bus2.WR = 1'b1;
    @(posedge clk); #1;
    bus2.WR = 1'b0;
    @(negedge clk);
    while (bus2.DMA_ACTIVE !== 1'b1 && pre < 1000) begin
      if (bus2.MMIO_DATA_in !== 8'hC4) bad++;
      pre++; @(negedge clk);
    end
    while (bus2.DMA_ACTIVE === 1'b1 && act < 1000) begin
      if (bus2.MMIO_DATA_in !== 8'hC4) bad++;
      act++; @(negedge clk);
    end
    checks++; if (pre != 1) begin errors++; $display("FAIL fast_start_delay: got %0d, required 1", pre); end
    checks++; if (pre + act != 321) begin errors++; $display("FAIL fast_total: got %0d, required 321", pre + act); end
    checks++; if (bad != 0) begin errors++; $display("FAIL fast_readback: got %0d bad clocks, required 0", bad); end
    checks++; if (n2_wr != 160 || sb2.size() != 0) begin errors++; $display("FAIL fast_wr_count: got %0d writes %0d left, required 160 and 0", n2_wr, sb2.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_echo_mirror();
    test_restart();
    test_stall_and_reset();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
